// File: rtl/seq_decoder.sv
// seq_decoder: registered one-hot line decoder with level, pulse, scan and clear modes.
module seq_decoder #(
  parameter int N = 2,
  parameter int PULSE_W = 3,
  localparam int OUTS = 2 ** N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    sel,
  input  logic [1:0]      mode,
  input  logic            en,
  output logic [OUTS-1:0] dout,
  output logic            dout_valid,
  output logic            busy
);
  localparam int CW = ($clog2(PULSE_W) > N) ? $clog2(PULSE_W) : N;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PULSE, S_SCAN} state_e;
  state_e state_q, state_d;
  logic [OUTS-1:0] oh_q, oh_d, sel_oh;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      oh_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      oh_q <= oh_d;
      cnt_q <= cnt_d;
    end
  end
  assign sel_oh = {{(OUTS-1){1'b0}}, 1'b1} << sel;
  assign busy = (state_q == S_PULSE) | (state_q == S_SCAN);
  assign in_ready = ~busy;
  assign dout = en ? oh_q : '0;
  assign dout_valid = |oh_q;
  // A running sequence ignores requests; the last count clears the line and returns to idle.
  always_comb begin
    state_d = state_q;
    oh_d = oh_q;
    cnt_d = cnt_q;
    if (busy) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        oh_d = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        oh_d = (state_q == S_SCAN) ? {oh_q[OUTS-2:0], oh_q[OUTS-1]} : oh_q;
      end
    end else if (in_valid) begin
      state_d = (mode == 2'b00) ? S_HOLD : (mode == 2'b01) ? S_PULSE : (mode == 2'b10) ? S_SCAN : S_IDLE;
      oh_d = (mode == 2'b11) ? '0 : sel_oh;
      cnt_d = (mode == 2'b10) ? CW'(OUTS - 1) : CW'(PULSE_W - 1);
    end
  end
endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: directed vector table plus randomized run against a queue-based reference model.
module tb_seq_decoder;
  localparam int N = 2;
  localparam int PW = 3;
  localparam int OUTS = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, en = 1;
  logic [N-1:0] sel = '0;
  logic [1:0] mode = '0;
  logic in_ready, dout_valid, busy;
  logic [OUTS-1:0] dout;
  int tests = 0, fails = 0;

  seq_decoder #(.N(N), .PULSE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .mode(mode), .en(en), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: current line value plus a queue of the values still to come in a sequence.
  logic [OUTS-1:0] m_cur = '0;
  logic [OUTS-1:0] m_q[$];
  bit m_busy = 0;

  task automatic model_edge(input logic r, input logic v, input logic [1:0] md, input logic [N-1:0] s);
    logic [OUTS-1:0] base;
    base = OUTS'(1) << s;
    if (!r) begin
      m_cur = '0; m_q.delete(); m_busy = 0;
    end else if (m_busy) begin
      if (m_q.size() == 0) begin m_cur = '0; m_busy = 0; end
      else m_cur = m_q.pop_front();
    end else if (v) begin
      m_cur = (md == 2'b11) ? '0 : base;
      if (md == 2'b01) begin
        for (int i = 1; i < PW; i++) m_q.push_back(base);
        m_busy = 1;
      end else if (md == 2'b10) begin
        for (int i = 1; i < OUTS; i++) m_q.push_back(OUTS'((base << i) | (base >> (OUTS - i))));
        m_busy = 1;
      end
    end
  endtask

  task automatic step();
    logic r, v;
    logic [1:0] md;
    logic [N-1:0] s;
    r = rst_n; v = in_valid; md = mode; s = sel;
    @(posedge clk);
    model_edge(r, v, md, s);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [OUTS-1:0] d, input logic dv, input logic b, input logic rd);
    chk({tag, ".dout"}, 32'(dout), 32'(d));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(dv));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rd));
  endtask

  typedef struct {
    logic r, v; logic [1:0] m; logic [N-1:0] s; logic e;
    logic [OUTS-1:0] d; logic dv, b, rd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic [1:0] m, logic [N-1:0] s, logic e,
                              logic [OUTS-1:0] d, logic dv, logic b, logic rd);
    vec_t t;
    t.r = r; t.v = v; t.m = m; t.s = s; t.e = e; t.d = d; t.dv = dv; t.b = b; t.rd = rd;
    return t;
  endfunction

  initial begin
    // Reset, then LEVEL sel=2 held for 10 cycles.
    step();
    chk_all("reset", 4'b0000, 0, 0, 1);
    rst_n = 1; in_valid = 1; mode = 2'b00; sel = 2;
    step();
    in_valid = 0;
    chk_all("level", 4'b0100, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("hold", 4'b0100, 1, 0, 1);
    end
    tbl.push_back(mk(1, 1, 2'b00, 1, 1, 4'b0010, 1, 0, 1));
    tbl.push_back(mk(1, 1, 2'b01, 3, 1, 4'b1000, 1, 1, 0));
    tbl.push_back(mk(1, 1, 2'b00, 0, 1, 4'b1000, 1, 1, 0));
    tbl.push_back(mk(1, 1, 2'b10, 0, 1, 4'b1000, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 1, 2'b10, 2, 1, 4'b0100, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 1, 4'b1000, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 4'b0000, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 1, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 1, 2'b00, 3, 1, 4'b1000, 1, 0, 1));
    tbl.push_back(mk(1, 1, 2'b11, 1, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 1, 2'b01, 0, 1, 4'b0001, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2'b00, 1, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 0, 2'b00, 1, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 1, 2'b00, 1, 1, 4'b0010, 1, 0, 1));
    tbl.push_back(mk(1, 1, 2'b01, 2, 1, 4'b0100, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 2, 0, 4'b0000, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 2, 1, 4'b0100, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 2, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(1, 1, 2'b10, 3, 1, 4'b1000, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 1, 4'b0001, 1, 1, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 1, 4'b0000, 0, 0, 1));
    foreach (tbl[i]) begin
      rst_n = tbl[i].r; in_valid = tbl[i].v; mode = tbl[i].m; sel = tbl[i].s; en = tbl[i].e;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].d, tbl[i].dv, tbl[i].b, tbl[i].rd);
    end
    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      in_valid = $urandom_range(0, 1);
      mode = 2'($urandom_range(0, 3));
      sel = N'($urandom_range(0, OUTS - 1));
      en = ($urandom_range(0, 7) != 0);
      step();
      chk_all("rand", en ? m_cur : '0, m_cur != 0, m_busy, !m_busy);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
